// File: rtl/vm_pkg.sv
// Shared types and constants for the vending-machine sequencing controller.
// Coin values, the controller state enum and the default balance width live here.
package vm_pkg;

    localparam int BAL_W_DEF  = 16;
    localparam int COIN_1000  = 1000;
    localparam int COIN_500   = 500;
    localparam int COIN_100   = 100;
    localparam int COIN_50    = 50;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADD,
        ST_VEND,
        ST_CHG,
        ST_SETTLE
    } state_t;

    // Value of a one-hot {1000, 500, 100, 50} coin selection; zero when nothing is selected.
    function automatic int coin_value(input logic [3:0] sel);
        int val;
        val = 0;
        if (sel[3]) val = COIN_1000;
        else if (sel[2]) val = COIN_500;
        else if (sel[1]) val = COIN_100;
        else if (sel[0]) val = COIN_50;
        return val;
    endfunction

endpackage

// File: rtl/vm_change_sel.sv
// Picks the largest coin not exceeding the balance, as a one-hot {1000, 500, 100, 50} vector.
// Output is all-zero when the balance is below the smallest coin.
module vm_change_sel
    import vm_pkg::*;
#(
    parameter int BAL_W = BAL_W_DEF
) (
    input  logic [BAL_W-1:0] i_balance,
    output logic [3:0]       o_sel
);

    always_comb begin
        o_sel = 4'b0000;
        if (i_balance >= BAL_W'(COIN_1000))     o_sel = 4'b1000;
        else if (i_balance >= BAL_W'(COIN_500)) o_sel = 4'b0100;
        else if (i_balance >= BAL_W'(COIN_100)) o_sel = 4'b0010;
        else if (i_balance >= BAL_W'(COIN_50))  o_sel = 4'b0001;
    end

endmodule

// File: rtl/vending_ctrl_fsm.sv
// Vending controller: converts coin/buy/return pulses into money-register strobes.
// Optional per-juice stock counting and EMPTY outputs are enabled by defining VM_STOCK_COUNT_EN.
module vending_ctrl_fsm
    import vm_pkg::*;
#(
    parameter int BAL_W   = BAL_W_DEF,
    parameter int MAX_BAL = 10000
`ifdef VM_STOCK_COUNT_EN
    ,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 8
`endif
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_coin_1000,
    input  logic             i_coin_500,
    input  logic             i_coin_100,
    input  logic             i_coin_50,
    input  logic             i_buy0,
    input  logic             i_buy1,
    input  logic             i_return,
    input  logic [BAL_W-1:0] i_balance,
    input  logic [BAL_W-1:0] i_juice0_price,
    input  logic [BAL_W-1:0] i_juice1_price,
    output logic             o_plus_1000,
    output logic             o_plus_500,
    output logic             o_plus_100,
    output logic             o_plus_50,
    output logic             o_minus_1000,
    output logic             o_minus_500,
    output logic             o_minus_100,
    output logic             o_minus_50,
    output logic             o_minus_juice,
    output logic             o_juice_kind,
    output logic             o_vend0,
    output logic             o_vend1,
    output logic             o_reject,
    output logic             o_busy
`ifdef VM_STOCK_COUNT_EN
    ,
    output logic             o_empty0,
    output logic             o_empty1
`endif
);

    state_t           r_state;
    state_t           w_state_next;
    logic             r_prev_chg;
    logic [3:0]       r_plus, r_minus;
    logic [3:0]       w_plus_next, w_minus_next;
    logic             r_minus_juice, r_kind, r_reject, r_busy;
    logic [1:0]       r_vend;
    logic             w_minus_juice_next, w_kind_next, w_reject_next;
    logic [1:0]       w_vend_next;
    logic [3:0]       w_coins, w_coin_sel, w_chg_sel;
    logic             w_coin_any, w_coin_ok, w_chg_any;
    logic [BAL_W:0]   w_coin_val;
    logic [1:0]       w_stock_ok, w_buy_ok;

    assign w_coins    = {i_coin_1000, i_coin_500, i_coin_100, i_coin_50};
    assign w_coin_any = |w_coins;

    always_comb begin
        w_coin_sel = 4'b0000;
        if (w_coins[3])      w_coin_sel = 4'b1000;
        else if (w_coins[2]) w_coin_sel = 4'b0100;
        else if (w_coins[1]) w_coin_sel = 4'b0010;
        else if (w_coins[0]) w_coin_sel = 4'b0001;
    end

    // One extra bit keeps BALANCE + coin from wrapping before the limit compare.
    assign w_coin_val = (BAL_W + 1)'(coin_value(w_coin_sel));
    assign w_coin_ok  = ({1'b0, i_balance} + w_coin_val) <= (BAL_W + 1)'(MAX_BAL);

    vm_change_sel #(.BAL_W(BAL_W)) u_change_sel (
        .i_balance (i_balance),
        .o_sel     (w_chg_sel)
    );
    assign w_chg_any = |w_chg_sel;

`ifdef VM_STOCK_COUNT_EN
    logic [STOCK_W-1:0] r_stock [2];

    always_ff @(posedge i_clk) begin
        for (int k = 0; k < 2; k++) begin
            if (i_rst)
                r_stock[k] <= STOCK_W'(STOCK_INIT);
            else if (w_vend_next[k] && (r_stock[k] != '0))
                r_stock[k] <= r_stock[k] - 1'b1;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_stock
        assign w_stock_ok[gi] = (r_stock[gi] != '0);
    end
    assign o_empty0 = ~w_stock_ok[0];
    assign o_empty1 = ~w_stock_ok[1];
`else
    assign w_stock_ok = 2'b11;
`endif

    assign w_buy_ok[0] = (i_balance >= i_juice0_price) && w_stock_ok[0];
    assign w_buy_ok[1] = (i_balance >= i_juice1_price) && w_stock_ok[1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_prev_chg    <= 1'b0;
            r_plus        <= '0;
            r_minus       <= '0;
            r_minus_juice <= 1'b0;
            r_kind        <= 1'b0;
            r_vend        <= '0;
            r_reject      <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_prev_chg    <= (r_state == ST_CHG);
            r_plus        <= w_plus_next;
            r_minus       <= w_minus_next;
            r_minus_juice <= w_minus_juice_next;
            r_kind        <= w_kind_next;
            r_vend        <= w_vend_next;
            r_reject      <= w_reject_next;
            r_busy        <= (w_state_next != ST_IDLE);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_return) begin
                    if (w_chg_any) w_state_next = ST_CHG;
                end else if (i_buy0) begin
                    if (w_buy_ok[0]) w_state_next = ST_VEND;
                end else if (i_buy1) begin
                    if (w_buy_ok[1]) w_state_next = ST_VEND;
                end else if (w_coin_any && w_coin_ok) begin
                    w_state_next = ST_ADD;
                end
            end
            ST_ADD, ST_VEND, ST_CHG: w_state_next = ST_SETTLE;
            // The change loop re-reads BALANCE here, after the last MINUS has landed.
            ST_SETTLE: w_state_next = (r_prev_chg && w_chg_any) ? ST_CHG : ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_plus_next        = '0;
        w_minus_next       = '0;
        w_minus_juice_next = 1'b0;
        w_kind_next        = r_kind;
        w_vend_next        = '0;
        w_reject_next      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_return) begin
                    w_minus_next = w_chg_sel;
                end else if (i_buy0 || i_buy1) begin
                    if (w_buy_ok[i_buy0 ? 0 : 1]) begin
                        w_minus_juice_next       = 1'b1;
                        w_kind_next              = ~i_buy0;
                        w_vend_next[i_buy0 ? 0 : 1] = 1'b1;
                    end else begin
                        w_reject_next = 1'b1;
                    end
                end else if (w_coin_any) begin
                    if (w_coin_ok) w_plus_next = w_coin_sel;
                    else           w_reject_next = 1'b1;
                end
            end
            ST_SETTLE: begin
                w_reject_next = w_coin_any;
                if (r_prev_chg) w_minus_next = w_chg_sel;
            end
            default: w_reject_next = w_coin_any;
        endcase
    end

    assign {o_plus_1000, o_plus_500, o_plus_100, o_plus_50}     = r_plus;
    assign {o_minus_1000, o_minus_500, o_minus_100, o_minus_50} = r_minus;
    assign o_minus_juice = r_minus_juice;
    assign o_juice_kind  = r_kind;
    assign o_vend0       = r_vend[0];
    assign o_vend1       = r_vend[1];
    assign o_reject      = r_reject;
    assign o_busy        = r_busy;

endmodule
